load_store_unit: RTL and testbench

//  Data-memory side of the core: consumes ALU_result (address), WriteData and funct3 from the datapath, returns ReadData.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/load_store_unit_align.sv | 80 ++++++++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared constants for the load/store unit: funct3 access-size codes,
//   FSM state encoding and the legality rule for a requested access.
//   No ports (package).
// ---------------------------------------------------------------------------
package lsu_pkg;

    // funct3 codes (instr[14:12]) understood by the unit
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // 1 = the access cannot be issued: unknown funct3, unsigned store,
    // or an address not aligned to the access size.
    function automatic logic access_illegal(input logic [2:0] f3,
                                            input logic       is_store,
                                            input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic of the load/store unit.
//   Request side : byte enables, store-data replication, illegal decode.
//   Response side: byte/half extraction from the bus word with sign or
//                  zero extension, driven by the latched funct3/offset.
// Ports
//   req_funct3_i  in  3   funct3 of the request being issued
//   req_off_i     in  2   addr[1:0] of the request
//   req_store_i   in  1   request is a store
//   req_wdata_i   in  32  raw store data (rs2)
//   req_be_o      out 4   byte enables for the request
//   req_wdata_o   out 32  lane-replicated store data
//   req_illegal_o out 1   access is misaligned or not a legal encoding
//   ld_funct3_i   in  3   latched funct3 of the load in flight
//   ld_off_i      in  2   latched addr[1:0] of the load in flight
//   ld_word_i     in  32  word returned by the bus
//   ld_data_o     out 32  extended load result
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_off_i,
    input  logic        req_store_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_illegal_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_illegal_o = access_illegal(req_funct3_i, req_store_i, req_off_i);

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        req_be_o    = 4'b1111;
        req_wdata_o = req_wdata_i;
        // funct3[1:0] is the size for both signed and unsigned loads
        case (req_funct3_i[1:0])
            2'b00: begin
                req_be_o    = 4'b0001 << req_off_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_be_o    = req_off_i[1] ? 4'b1100 : 4'b0011;
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            default: begin
                req_be_o    = 4'b1111;
                req_wdata_o = req_wdata_i;
            end
        endcase
    end

    assign shifted = ld_word_i >> {ld_off_i, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    always_comb begin
        ld_data_o = '0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'd0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'd0, ld_half};
            F3_W:    ld_data_o = ld_word_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Data-memory side of the core. Turns a load/store request from the
//   datapath into one req/ack bus transaction, stalls the datapath while the
//   access is outstanding and returns the extended load data for one cycle.
//   IDLE -> BUSY (bus_req held) -> DONE (stall released, rdata valid) -> IDLE
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_read/mem_write  level requests from the decoder (write wins)
//   funct3, addr, wdata access size/sign, byte address, store data
//   rdata               extended load data, valid in DONE, 0 otherwise
//   stall               hold PC / suppress RegWrite
//   misalign            illegal access requested (combinational)
//   timeout_err         one-cycle pulse when an access is aborted
//   bus_*               registered request fields; bus_ack/bus_rdata return
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             terr_q, terr_d;

    logic        any_req, illegal, access;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, ld_data;

    lsu_align u_align (
        .req_funct3_i  (funct3),
        .req_off_i     (addr[1:0]),
        .req_store_i   (mem_write),
        .req_wdata_i   (wdata),
        .req_be_o      (req_be),
        .req_wdata_o   (req_wdata),
        .req_illegal_o (illegal),
        .ld_funct3_i   (f3_q),
        .ld_off_i      (off_q),
        .ld_word_i     (bus_rdata),
        .ld_data_o     (ld_data)
    );

    assign any_req  = mem_read | mem_write;
    assign misalign = any_req & illegal;
    assign access   = any_req & ~illegal;

    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = access;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                rdata_d = '0;
                if (access) begin
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = mem_write ? req_wdata : '0;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : ld_data;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // abort: the core still gets its DONE cycle, with rdata=0
                    req_d   = 1'b0;
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking '<=' so every register samples
    // the pre-edge values; reset clears all of them since each is visible on
    // a port or steers the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
        end
    end

    assign rdata       = rdata_q;
    assign timeout_err = terr_q;
    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. A behavioural model derives the
//   expected enables, store data, load results and legality from the access
//   rules using plain arithmetic; a driver task plays both the datapath and
//   the memory (acknowledging after a chosen number of request cycles).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, timeout_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // observations from the last run_access
    logic [31:0] r_rdata, r_wd, r_addr;
    logic [3:0]  r_be;
    logic        r_we, r_terr, r_mis, r_hung, r_dirty;
    int          r_stall, r_req;

    load_store_unit #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .timeout_err(timeout_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic logic m_illegal(input logic [2:0] f3, input logic st, input logic [31:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (st && f3 >= 4) return 1'b1;
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    // ack_lat = number of bus_req cycles before ack (0 = never ack)
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_lat, input logic [31:0] word);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        r_stall = 0; r_req = 0; r_be = 'x; r_wd = 'x; r_addr = 'x; r_we = 'x;
        r_hung = 1'b1; r_dirty = 1'b0; r_rdata = 'x; r_terr = 'x;
        #1;
        r_mis = misalign;
        for (int c = 0; c < 200; c++) begin
            if (c != 0) begin
                @(negedge clk);
                #1;
            end
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                r_req++;
                r_be = bus_be; r_wd = bus_wdata; r_addr = bus_addr; r_we = bus_we;
                if (ack_lat != 0 && r_req == ack_lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = word;
                end
            end
            if (stall) begin
                r_stall++;
                if (rdata !== 32'd0) r_dirty = 1'b1;
            end else begin
                r_rdata = rdata;
                r_terr  = timeout_err;
                r_hung  = 1'b0;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        tests_run++;
        if (r_hung !== 1'b0) begin
            tests_failed++;
            $display("FAIL access_bound: stall never released (f3=%0d addr=%h)", f3, a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({bus_req, bus_we, bus_be, stall, timeout_err} !== 8'd0 ||
            bus_addr !== 0 || bus_wdata !== 0 || rdata !== 0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b we=%b be=%b addr=%h wd=%h rdata=%h stall=%b terr=%b exp all 0",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, stall, timeout_err);
        end
    endtask

    task automatic test_directed;
        run_access(1, 0, 3'b010, 32'h100, 0, 1, 32'hDEAD_BEEF);
        tests_run++;
        if (r_be !== 4'b1111 || r_addr !== 32'h100 || r_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_bus: be=%b addr=%h we=%b exp 1111 00000100 0", r_be, r_addr, r_we);
        end
        tests_run++;
        if (r_stall != 2 || r_req != 1) begin
            tests_failed++;
            $display("FAIL lw_latency: stall_cycles=%0d req_cycles=%0d exp 2 1", r_stall, r_req);
        end
        tests_run++;
        if (r_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lw_rdata: got %h exp deadbeef", r_rdata);
        end

        run_access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_0000);
        tests_run++;
        if (r_rdata !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_rdata: got %h exp ffffff80", r_rdata);
        end
        run_access(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FF_0000);
        tests_run++;
        if (r_rdata !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL lbu_rdata: got %h exp 00000080", r_rdata);
        end
        run_access(1, 0, 3'b101, 32'h102, 0, 1, 32'h80FF_0000);
        tests_run++;
        if (r_rdata !== 32'h0000_80FF || r_be !== 4'b1100) begin
            tests_failed++;
            $display("FAIL lhu_rdata: got %h be=%b exp 000080ff 1100", r_rdata, r_be);
        end

        run_access(0, 1, 3'b000, 32'h201, 32'h0000_00AB, 1, 32'hFFFF_FFFF);
        tests_run++;
        if (r_we !== 1'b1 || r_be !== 4'b0010 || r_wd !== 32'hABAB_ABAB || r_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL sb_bus: we=%b be=%b wd=%h addr=%h exp 1 0010 abababab 00000200",
                     r_we, r_be, r_wd, r_addr);
        end
        tests_run++;
        if (r_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL sb_rdata: got %h exp 0", r_rdata);
        end
    endtask

    task automatic test_misalign;
        run_access(1, 0, 3'b010, 32'h102, 0, 1, 32'h1234_5678);
        tests_run++;
        if (r_mis !== 1'b1 || r_stall != 0 || r_req != 0 || r_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL lw_misalign: mis=%b stall_cycles=%0d req_cycles=%0d rdata=%h exp 1 0 0 0",
                     r_mis, r_stall, r_req, r_rdata);
        end
    endtask

    task automatic test_timeout;
        run_access(1, 0, 3'b010, 32'h300, 0, 0, 0);
        tests_run++;
        if (r_req != TO || r_stall != TO + 1) begin
            tests_failed++;
            $display("FAIL timeout_len: req_cycles=%0d stall_cycles=%0d exp %0d %0d",
                     r_req, r_stall, TO, TO + 1);
        end
        tests_run++;
        if (r_terr !== 1'b1 || r_rdata !== 32'd0 || bus_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_done: terr=%b rdata=%h req=%b exp 1 0 0", r_terr, r_rdata, bus_req);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (timeout_err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_pulse: terr=%b stall=%b req=%b exp 0 0 0", timeout_err, stall, bus_req);
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        mem_read = 1; funct3 = 3'b010; addr = 32'h400;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_busy_pre: req=%b exp 1", bus_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy_drop: req=%b stall=%b exp 0 0", bus_req, stall);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy_ack: req=%b stall=%b rdata=%h terr=%b exp 0 0 0 0",
                     bus_req, stall, rdata, timeout_err);
        end
    endtask

    task automatic test_random;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] a, wd, w;
        int          lat;
        logic        st, bad;
        for (int i = 0; i < 60; i++) begin
            sel = 2'($urandom_range(1, 3));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            wd  = $urandom;
            w   = $urandom;
            lat = $urandom_range(1, 5);
            st  = sel[1];
            bad = m_illegal(f3, st, a);
            run_access(sel[0], sel[1], f3, a, wd, lat, w);
            tests_run++;
            if (bad) begin
                if (r_mis !== 1'b1 || r_req != 0 || r_stall != 0 || r_rdata !== 32'd0) begin
                    tests_failed++;
                    $display("FAIL rnd_illegal[%0d]: f3=%0d st=%b addr=%h mis=%b req_cycles=%0d rdata=%h exp 1 0 0",
                             i, f3, st, a, r_mis, r_req, r_rdata);
                end
            end else begin
                if (r_mis !== 1'b0 || r_req != lat || r_stall != lat + 1 || r_dirty !== 1'b0 ||
                    r_be !== m_be(f3, a) || r_addr !== {a[31:2], 2'b00} || r_we !== st ||
                    (st && r_wd !== m_wdata(f3, wd)) ||
                    r_rdata !== (st ? 32'd0 : m_rdata(f3, a, w))) begin
                    tests_failed++;
                    $display("FAIL rnd_access[%0d]: f3=%0d st=%b addr=%h be=%b/%b wd=%h/%h rdata=%h/%h stall=%0d/%0d (got/exp)",
                             i, f3, st, a, r_be, m_be(f3, a), r_wd, m_wdata(f3, wd),
                             r_rdata, st ? 32'd0 : m_rdata(f3, a, w), r_stall, lat + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
